// File: rtl/udp_stack_pkg.sv
// Shared definitions for the UDP stack: FIFO word packing, reader states and frame limits.
package udp_stack_pkg;

    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned MAX_WORDS_DEF = 190;

    // Word packing is {last, keep, data}; offsets below are for the default 64-bit data path.
    localparam int unsigned KEEP_LSB = DATA_W_DEF;
    localparam int unsigned LAST_BIT = DATA_W_DEF + DATA_W_DEF / 8;

    // Offsets for an arbitrary data width.
    function automatic int unsigned keep_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned last_bit(input int unsigned data_w);
        return data_w + data_w / 8;
    endfunction

    typedef enum logic [0:0] {
        PASS,
        DISCARD
    } rd_state_e;

endpackage

// File: rtl/fifo_axis_rd_buf.sv
// Three-entry register FIFO that absorbs the FIFO read latency in front of the stream output.
module fifo_axis_rd_buf #(
    parameter int unsigned W = 73
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);
    import udp_stack_pkg::*;

    logic [W-1:0] mem_q [3];
    logic [W-1:0] mem_d [3];
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   occ_q, occ_d;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < 3; i++) mem_d[i] = mem_q[i];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) mem_q[i] <= mem_d[i];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a latency-1 standard-mode FIFO into an AXI4-Stream master, truncating runaway frames.
// Optional statistics counters are compiled in with FIFO_AXIS_RD_STATS_EN.
module fifo_axis_reader
    import udp_stack_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned KEEP_W    = DATA_W / 8,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W+KEEP_W:0]     fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [KEEP_W-1:0]          m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       trunc_pulse,
    output logic [31:0]                frame_cnt,
    output logic [15:0]                trunc_cnt
);

    localparam int unsigned FW   = DATA_W + KEEP_W + 1;
    localparam int unsigned LBIT = DATA_W + KEEP_W;
    localparam int unsigned WCW  = $clog2(MAX_WORDS);
    localparam logic [WCW-1:0] WC_LAST = WCW'(MAX_WORDS - 1);

    rd_state_e      state_q, state_d;
    logic           inflight_q, inflight_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]     occ;
    logic [FW-1:0]  head;
    logic [FW-1:0]  push_word;
    logic           push;
    logic           pop;
    logic           landed_last;

    // Credit check: buffered plus in-flight words must leave room for the word being requested.
    assign fifo_rd_en  = !fifo_empty && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd3);
    assign inflight_d  = fifo_rd_en;
    assign landed_last = fifo_dout[LBIT];

    // Landed-word handling: pass, truncate or drop depending on frame state.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        push        = 1'b0;
        push_word   = fifo_dout;
        trunc_pulse = 1'b0;
        if (inflight_q) begin
            unique case (state_q)
                PASS: begin
                    push = 1'b1;
                    if (landed_last) begin
                        word_cnt_d = '0;
                    end else if (word_cnt_q == WC_LAST) begin
                        push_word[LBIT] = 1'b1;
                        trunc_pulse     = 1'b1;
                        word_cnt_d      = '0;
                        state_d         = DISCARD;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                DISCARD: begin
                    if (landed_last) state_d = PASS;
                end
                default: state_d = PASS;
            endcase
        end
    end

    // Read-tracking and frame-state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PASS;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    fifo_axis_rd_buf #(
        .W (FW)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (push_word),
        .pop  (pop),
        .occ  (occ),
        .head (head)
    );

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = head[DATA_W-1:0];
    assign m_axis_tkeep  = head[LBIT-1:DATA_W];
    assign m_axis_tlast  = head[LBIT];
    assign pop           = m_axis_tvalid && m_axis_tready;

`ifdef FIFO_AXIS_RD_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] trunc_cnt_q, trunc_cnt_d;

    // Frame counter wraps; truncation counter saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (pop && m_axis_tlast) frame_cnt_d = frame_cnt_q + 32'd1;
        if (trunc_pulse && (trunc_cnt_q != 16'hFFFF)) trunc_cnt_d = trunc_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
`else
    assign frame_cnt = '0;
    assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader with a latency-1 FIFO model and an expected-beat queue.
module tb_fifo_axis_reader;
    import udp_stack_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;
    localparam int unsigned FW = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          trunc_pulse;
    logic [31:0]   frame_cnt;
    logic [15:0]   trunc_cnt;

    int n_vec = 0;
    int n_err = 0;
    int trunc_seen = 0;

    logic [FW-1:0] fq [$];
    logic [FW-1:0] exp_q [$];

    fifo_axis_reader #(
        .DATA_W    (64),
        .KEEP_W    (8),
        .MAX_WORDS (190)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .trunc_pulse   (trunc_pulse),
        .frame_cnt     (frame_cnt),
        .trunc_cnt     (trunc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int fid, input int idx, input bit last,
                                         input logic [7:0] keep);
        logic [63:0] d;
        d = (64'(fid) << 32) | 64'(idx) | 64'hA500_0000_0000_0000;
        return {last, keep, d};
    endfunction

    // Latency-1 FIFO model; the empty flag is refreshed once per cycle.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_dout <= '0;
        end else if (fifo_rd_en && fq.size() != 0) begin
            fifo_dout <= fq.pop_front();
        end
    end

    always @(negedge clk) fifo_empty = (fq.size() == 0);

    // Stream monitor: in-order beat check and hold-during-stall check.
    logic          stall_q = 1'b0;
    logic [FW-1:0] held = '0;
    always @(negedge clk) begin
        logic [FW-1:0] beat;
        #1;
        beat = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (!rst) begin
            if (stall_q && m_axis_tvalid) check_eq("stall_hold", beat, held);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) check_eq("extra_beat", exp_q.size(), 1);
                else check_eq("beat", beat, exp_q.pop_front());
            end
            if (trunc_pulse) trunc_seen++;
            stall_q = m_axis_tvalid && !m_axis_tready;
            held    = beat;
        end
    end

    // Source frame into the FIFO model: last and short keep only on the final word if has_last.
    task automatic load_frame(input int fid, input int n, input bit has_last);
        for (int i = 0; i < n; i++) begin
            fq.push_back(mk(fid, i, has_last && (i == n - 1),
                            (has_last && (i == n - 1)) ? 8'h0F : 8'hFF));
        end
    endtask

    // Expected output: first n_emit of an n_src-word frame, last on the final emitted word.
    task automatic expect_frame(input int fid, input int n_emit, input int n_src);
        for (int i = 0; i < n_emit; i++) begin
            exp_q.push_back(mk(fid, i, i == n_emit - 1, (i == n_src - 1) ? 8'h0F : 8'hFF));
        end
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && budget < 600) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    localparam logic [3:0] TREADY_PAT = 4'b1001;

    initial begin
        logic [7:0] rd_hist, vld_hist, last_hist;
        int         vcnt, first, last, cyc;
        logic [31:0] exp_frames;
        logic [15:0] exp_trunc;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_payload", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        check_eq("rst_trunc_pulse", trunc_pulse, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);

        // 4-word frame: rd_en cycles N..N+3, tvalid N+2..N+5, tlast at N+5.
        @(posedge clk);
        #1;
        expect_frame(1, 4, 4);
        load_frame(1, 4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            rd_hist[i]   = fifo_rd_en;
            vld_hist[i]  = m_axis_tvalid;
            last_hist[i] = m_axis_tvalid && m_axis_tlast;
        end
        check_eq("s1_rd_en_seq", rd_hist, 8'h0F);
        check_eq("s1_tvalid_seq", vld_hist, 8'h3C);
        check_eq("s1_tlast_seq", last_hist, 8'h20);
        wait_drain("s1_drain");
`ifdef FIFO_AXIS_RD_STATS_EN
        exp_frames = 32'd1;
`else
        exp_frames = 32'd0;
`endif
        check_eq("s1_frame_cnt", frame_cnt, exp_frames);

        // Two back-to-back 100-word frames: 200 valid cycles, no bubble.
        @(posedge clk);
        #1;
        expect_frame(2, 100, 100);
        expect_frame(3, 100, 100);
        load_frame(2, 100, 1'b1);
        load_frame(3, 100, 1'b1);
        vcnt = 0; first = -1; last = -1;
        for (cyc = 0; cyc < 230; cyc++) begin
            @(negedge clk);
            #1;
            if (m_axis_tvalid) begin
                if (first < 0) first = cyc;
                last = cyc;
                vcnt++;
            end
        end
        check_eq("s2_valid_cycles", vcnt, 200);
        check_eq("s2_span", last - first, 199);
        wait_drain("s2_drain");

        // 50-word frame under tready 1,0,0,1 backpressure.
        @(posedge clk);
        #1;
        expect_frame(4, 50, 50);
        load_frame(4, 50, 1'b1);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
            m_axis_tready = TREADY_PAT[k % 4];
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        wait_drain("s3_drain");

        // Runaway 200-word frame truncated at 190, then an intact 4-word frame.
        @(posedge clk);
        #1;
        expect_frame(5, 190, 200);
        expect_frame(6, 4, 4);
        load_frame(5, 200, 1'b1);
        load_frame(6, 4, 1'b1);
        wait_drain("s4_drain");
        check_eq("s4_trunc_pulses", trunc_seen, 1);
`ifdef FIFO_AXIS_RD_STATS_EN
        exp_frames = 32'd6;
        exp_trunc  = 16'd1;
`else
        exp_frames = 32'd0;
        exp_trunc  = 16'd0;
`endif
        check_eq("s4_frame_cnt", frame_cnt, exp_frames);
        check_eq("s4_trunc_cnt", trunc_cnt, exp_trunc);
        check_eq("s4_state", dut.state_q, PASS);

        // Mid-frame reset with the buffer full under backpressure.
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        load_frame(7, 20, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_eq("s5_occ_full", dut.occ, 3);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("s5_tvalid", m_axis_tvalid, 0);
        check_eq("s5_rd_en", fifo_rd_en, 0);
        check_eq("s5_payload", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
        check_eq("s5_frame_cnt", frame_cnt, 0);
        check_eq("s5_trunc_cnt", trunc_cnt, 0);
        check_eq("s5_state", dut.state_q, PASS);
        check_eq("s5_word_cnt", dut.word_cnt_q, 0);
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
